// File: rtl/red_serial_if.sv
// Operand/result handshake bundle for the serial byte-reduction engine.
// The master side issues operand pairs and consumes results; the slave is the engine.
interface red_serial_if #(parameter int OUT_W = 16);
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      a;
   logic [15:0]      b;
   logic             abort;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] result;
   logic             zero;

   modport master (
      output in_valid, a, b, abort, out_ready,
      input  in_ready, out_valid, result, zero
   );

   modport slave (
      input  in_valid, a, b, abort, out_ready,
      output in_ready, out_valid, result, zero
   );
endinterface

// File: rtl/red_serial.sv
// Multicycle byte-reduction engine: sums the four bytes of {b,a} one byte per
// cycle through a single 10-bit adder and holds the extended sum until accepted.
module red_serial #(
   parameter int OUT_W  = 16,
   parameter int SIGNED = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   red_serial_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [9:0]       acc_q, acc_d;
   logic [31:0]      opnd_q, opnd_d;
   logic [OUT_W-1:0] result_q, result_d;
   logic             zero_q, zero_d;

   logic             in_ready_s;
   logic             accept_s;
   logic [7:0]       cur_byte_s;
   logic [9:0]       sum_s;

   function automatic logic [9:0] ext_byte(input logic [7:0] v);
      return (SIGNED != 0) ? {{2{v[7]}}, v} : {2'b00, v};
   endfunction

   function automatic logic [OUT_W-1:0] ext_sum(input logic [9:0] v);
      logic [OUT_W-1:0] r;
      r      = '0;
      r[9:0] = v;
      for (int i = 10; i < OUT_W; i++) begin
         r[i] = (SIGNED != 0) ? v[9] : 1'b0;
      end
      return r;
   endfunction

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort overrides every other transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.abort)         state_d = IDLE;
            else if (bus.in_valid) state_d = ACC;
            else                   state_d = IDLE;
         end
         ACC: begin
            if (bus.abort)           state_d = IDLE;
            else if (cnt_q == 2'd3)  state_d = DONE;
            else                     state_d = ACC;
         end
         DONE: begin
            if (bus.abort)          state_d = IDLE;
            else if (bus.out_ready) state_d = bus.in_valid ? ACC : IDLE;
            else                    state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode; in_ready depends only on state and out_ready.
   always_comb begin
      in_ready_s    = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
      bus.in_ready  = in_ready_s;
      bus.out_valid = (state_q == DONE);
      bus.result    = result_q;
      bus.zero      = zero_q;
   end

   // Datapath next values: operand capture, serial accumulate, result latch.
   always_comb begin
      accept_s   = bus.in_valid & in_ready_s & ~bus.abort;
      cur_byte_s = opnd_q[{cnt_q, 3'b000} +: 8];
      sum_s      = acc_q + ext_byte(cur_byte_s);
      opnd_d     = opnd_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      zero_d     = zero_q;
      if (bus.abort) begin
         cnt_d = 2'd0;
      end else if (accept_s) begin
         opnd_d = {bus.b, bus.a};
         acc_d  = 10'd0;
         cnt_d  = 2'd0;
      end else if (state_q == ACC) begin
         acc_d = sum_s;
         cnt_d = cnt_q + 2'd1;
         if (cnt_q == 2'd3) begin
            result_d = ext_sum(sum_s);
            zero_d   = (sum_s == 10'd0);
         end else begin
            result_d = result_q;
            zero_d   = zero_q;
         end
      end else begin
         acc_d = acc_q;
         cnt_d = cnt_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= 2'd0;
         acc_q    <= 10'd0;
         opnd_q   <= 32'd0;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

endmodule

// File: tb/tb_red_serial.sv
// Self-checking bench for red_serial: a signed and an unsigned instance run in
// lockstep on the same stimulus, checked against a byte-sum reference model.
module tb_red_serial;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        abort;
   logic        out_ready;
   logic [15:0] a;
   logic [15:0] b;

   always #5 clk = ~clk;

   red_serial_if #(.OUT_W(16)) if_s ();
   red_serial_if #(.OUT_W(16)) if_u ();

   assign if_s.in_valid  = in_valid;
   assign if_s.a         = a;
   assign if_s.b         = b;
   assign if_s.abort     = abort;
   assign if_s.out_ready = out_ready;
   assign if_u.in_valid  = in_valid;
   assign if_u.a         = a;
   assign if_u.b         = b;
   assign if_u.abort     = abort;
   assign if_u.out_ready = out_ready;

   red_serial #(.OUT_W(16), .SIGNED(1)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s));
   red_serial #(.OUT_W(16), .SIGNED(0)) u_dut_u (.clk(clk), .rst_n(rst_n), .bus(if_u));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp_s;
      logic [15:0] exp_u;
      logic        z_s;
      logic        z_u;
   } vec_t;

   vec_t vecs [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: arithmetic sum of the four bytes, truncated to the result width.
   function automatic logic [15:0] model(input logic [15:0] ma, input logic [15:0] mb, input bit sgn);
      int s;
      logic [7:0] by [4];
      by = '{ma[7:0], ma[15:8], mb[7:0], mb[15:8]};
      s  = 0;
      foreach (by[i]) begin
         s += sgn ? int'($signed(by[i])) : int'(by[i]);
      end
      return 16'(s);
   endfunction

   task automatic wait_done(output int lat);
      lat = 0;
      while (if_s.out_valid !== 1'b1 && lat < 12) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   // One full transaction from IDLE with out_ready held high.
   task automatic run_op(input logic [15:0] na, input logic [15:0] nb,
                         input logic [15:0] es, input logic [15:0] eu,
                         input logic zs, input logic zu, input string tag);
      int lat;
      a        = na;
      b        = nb;
      in_valid = 1'b1;
      check({tag, " in_ready"}, 32'(if_s.in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = 16'($urandom);
      b        = 16'($urandom);
      wait_done(lat);
      check({tag, " latency"}, 32'(lat), 32'd4);
      check({tag, " result_s"}, 32'(if_s.result), 32'(es));
      check({tag, " result_u"}, 32'(if_u.result), 32'(eu));
      check({tag, " zero_s"}, 32'(if_s.zero), 32'(zs));
      check({tag, " zero_u"}, 32'(if_u.zero), 32'(zu));
      check({tag, " out_valid_u"}, 32'(if_u.out_valid), 32'd1);
      @(posedge clk);
      #1;
      check({tag, " pulse_end"}, 32'(if_s.out_valid), 32'd0);
   endtask

   initial begin
      int          lat;
      logic [15:0] ra;
      logic [15:0] rb;
      logic        seen;

      vecs[0] = '{16'h0102, 16'h0304, 16'h000A, 16'h000A, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFC, 16'h03FC, 1'b0, 1'b0};
      vecs[2] = '{16'h8080, 16'h8080, 16'hFE00, 16'h0200, 1'b0, 1'b0};
      vecs[3] = '{16'h01FF, 16'h0000, 16'h0000, 16'h0100, 1'b1, 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      abort     = 1'b0;
      out_ready = 1'b1;
      a         = 16'h0000;
      b         = 16'h0000;
      #1;
      check("reset in_ready", 32'(if_s.in_ready), 32'd1);
      check("reset out_valid", 32'(if_s.out_valid), 32'd0);
      check("reset result", 32'(if_s.result), 32'd0);
      check("reset zero", 32'(if_s.zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 4; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].exp_s, vecs[i].exp_u,
                vecs[i].z_s, vecs[i].z_u, $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 20; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         run_op(ra, rb, model(ra, rb, 1'b1), model(ra, rb, 1'b0),
                model(ra, rb, 1'b1) == 16'd0, model(ra, rb, 1'b0) == 16'd0,
                $sformatf("rnd%0d", i));
      end

      // Backpressure, then handoff and accept on the same edge.
      out_ready = 1'b0;
      a         = 16'h0102;
      b         = 16'h0304;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_done(lat);
      check("bp latency", 32'(lat), 32'd4);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("bp out_valid", 32'(if_s.out_valid), 32'd1);
         check("bp result", 32'(if_s.result), 32'h000A);
         check("bp in_ready", 32'(if_s.in_ready), 32'd0);
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a         = 16'h0001;
      b         = 16'h0001;
      #1;
      check("b2b in_ready", 32'(if_s.in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("b2b handoff", 32'(if_s.out_valid), 32'd0);
      wait_done(lat);
      check("b2b latency", 32'(lat), 32'd4);
      check("b2b result_s", 32'(if_s.result), 32'h0002);
      check("b2b result_u", 32'(if_u.result), 32'h0002);
      @(posedge clk);
      #1;

      // Abort on the second ACC cycle.
      a        = 16'h1111;
      b        = 16'h2222;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort in_ready", 32'(if_s.in_ready), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         seen = seen | if_s.out_valid | if_u.out_valid;
         @(posedge clk);
         #1;
      end
      check("abort no out_valid", 32'(seen), 32'd0);

      // Abort beats in_valid: no accept.
      in_valid = 1'b1;
      abort    = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      abort    = 1'b0;
      check("abort beats accept", 32'(if_s.in_ready), 32'd1);

      // Abort while holding a result.
      out_ready = 1'b0;
      a         = 16'h0102;
      b         = 16'h0304;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_done(lat);
      check("done latency", 32'(lat), 32'd4);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort     = 1'b0;
      out_ready = 1'b1;
      check("done abort out_valid", 32'(if_s.out_valid), 32'd0);
      check("done abort result held", 32'(if_s.result), 32'h000A);

      // Asynchronous reset mid-ACC.
      a        = 16'h0505;
      b        = 16'h0505;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst in_ready", 32'(if_s.in_ready), 32'd1);
      check("rst out_valid", 32'(if_s.out_valid), 32'd0);
      check("rst result_s", 32'(if_s.result), 32'd0);
      check("rst result_u", 32'(if_u.result), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_op(16'h0102, 16'h0304, 16'h000A, 16'h000A, 1'b0, 1'b0, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
